// File: rtl/axim_mem_resp.sv
// -----------------------------------------------------------------------------
// axim_mem_resp
//
// AXI4 memory responder: the slave end of a reduced AXI4 master interface.
// It accepts INCR bursts on independent read and write channels and serves
// them from an internal word array. There are no IDs, every beat is the full
// data width, and every burst is INCR.
//
// Optional feature macro: AXIM_MEM_RESP_STALL_EN
//   When defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1) advances
//   every cycle. Whenever lfsr[0]=1, awready, arready and wready are held low
//   for that cycle. Valid outputs are never gated.
//   When undefined, the ready signals follow the FSMs only.
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        synchronous active-high reset
//   s_axi_aw{valid,ready,addr,len}   write address channel
//   s_axi_w{valid,ready,data,strb,last} write data channel
//   s_axi_b{valid,ready}       write response (always OKAY)
//   s_axi_ar{valid,ready,addr,len}   read address channel
//   s_axi_r{valid,ready,data,last}   read data channel
//   wlast_err                  sticky: a wlast disagreed with the awlen beat count
//
// Word index = addr[LSB +: log2(depth)]. Upper address bits and low byte
// bits are ignored. The index wraps modulo the array depth.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module axim_mem_resp #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  // write address
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  // write data
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  // write response
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  // read address
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  // read data
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  // status
  output logic                            wlast_err
);

  localparam int NB  = C_M_AXI_DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(C_MEM_DEPTH_WORDS);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // ---------------------------------------------------------------------------
  // Ready stall source
  // ---------------------------------------------------------------------------
  logic stall_d;

`ifdef AXIM_MEM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  // Ready flops are loaded from the next LFSR value, so a ready is low in
  // exactly the cycle where the LFSR register shows bit 0 set.
  assign stall_d = lfsr_d[0];
`else
  assign stall_d = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  w_state_e      w_state_q, w_state_d;
  logic [IW-1:0] w_idx_q, w_idx_d;
  logic [7:0]    w_cnt_q, w_cnt_d;
  logic          wlast_err_q, wlast_err_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic          mem_we;

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_cnt_d     = w_cnt_q;
    wlast_err_d = wlast_err_q;
    mem_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          w_idx_d   = s_axi_awaddr[LSB +: IW];
          w_cnt_d   = s_axi_awlen;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          // A beat landing on the reset edge is dropped with the burst.
          mem_we  = !rst;
          w_idx_d = w_idx_q + IDX_ONE;
          w_cnt_d = w_cnt_q - 8'd1;
          // Burst length is owned by awlen; wlast is only cross-checked.
          if (s_axi_wlast != (w_cnt_q == 8'd0)) wlast_err_d = 1'b1;
          if (w_cnt_q == 8'd0) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !stall_d;
    wready_d  = (w_state_d == W_DATA) && !stall_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_cnt_q     <= '0;
      wlast_err_q <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_cnt_q     <= w_cnt_d;
      wlast_err_q <= wlast_err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  r_state_e      r_state_q, r_state_d;
  logic [IW-1:0] r_idx_q, r_idx_d;    // index of the word currently on rdata
  logic [7:0]    r_cnt_q, r_cnt_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic          rd_en;
  logic [IW-1:0] rd_idx;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rd_en     = 1'b0;
    rd_idx    = r_idx_q + IDX_ONE;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_idx_d   = s_axi_araddr[LSB +: IW];
          r_cnt_d   = s_axi_arlen;
          rd_en     = 1'b1;
          rd_idx    = s_axi_araddr[LSB +: IW];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready && rvalid_q) begin
          if (r_cnt_q != 8'd0) begin
            // Prefetch the next word on the accepting edge so beats stream
            // back-to-back.
            r_idx_d = r_idx_q + IDX_ONE;
            r_cnt_d = r_cnt_q - 8'd1;
            rd_en   = 1'b1;
          end else begin
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE) && !stall_d;
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so byte enables map onto plain
  // single-write-port RAMs. The registered read samples the array before the
  // same-edge write lands, so a collision returns the old word.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [C_MEM_DEPTH_WORDS];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (mem_we && s_axi_wstrb[gi]) lane_mem[w_idx_q] <= s_axi_wdata[gi*8 +: 8];
      end

      always_ff @(posedge clk) begin
        if (rst)        lane_rd_q <= 8'h00;
        else if (rd_en) lane_rd_q <= lane_mem[rd_idx];
      end

      assign s_axi_rdata[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign wlast_err     = wlast_err_q;

endmodule

// File: tb/tb_axim_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_axim_mem_resp
//
// Directed bench for axim_mem_resp (default configuration). Stimulus tasks
// push the expected read beats into a queue; a monitor pops and compares on
// every R handshake. Write-side and status checks are made inline.
// -----------------------------------------------------------------------------
module tb_axim_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        wlast_err;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];        // {rlast, rdata}
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  always #5 clk = ~clk;

  axim_mem_resp dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .wlast_err     (wlast_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Read-beat monitor: compares each accepted R beat against the queue head.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && rvalid && rready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL r_unexpected: got rdata=%h rlast=%b, required no beat", rdata, rlast);
      end else begin
        e = exp_q.pop_front();
        if ({rlast, rdata} !== e) begin
          n_err++;
          $display("FAIL r_beat: got rlast=%b rdata=%h required rlast=%b rdata=%h",
                   rlast, rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic ar(input logic [31:0] addr, input int len);
    logic ok;
    int   t;
    arvalid = 1'b1; araddr = addr; arlen = len[7:0];
    ok = 1'b0; t = 0;
    while (!ok && t < 100) begin ok = arready; tick(); t++; end
    arvalid = 1'b0;
    chk("ar_handshake", {63'd0, ok}, 64'd1);
  endtask

  // Issue a read burst with rready held high; the caller has pushed the
  // expected beats. rvalid must stay high for exactly len+1 cycles.
  task automatic rd(input logic [31:0] addr, input int len);
    int c;
    rready = 1'b1;
    ar(addr, len);
    c = 0;
    while (rvalid && c < 1000) begin tick(); c++; end
    chk("rd_b2b_beats", 64'(c), 64'(len + 1));
    chk("rd_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Write burst from wd/ws; wlast is raised on beat last_pos.
  task automatic wr(input logic [31:0] addr, input int len, input int last_pos);
    logic ok;
    int   t;
    awvalid = 1'b1; awaddr = addr; awlen = len[7:0];
    ok = 1'b0; t = 0;
    while (!ok && t < 100) begin ok = awready; tick(); t++; end
    awvalid = 1'b0;
    chk("aw_handshake", {63'd0, ok}, 64'd1);
    chk("aw_busy_w_ready", {62'd0, awready, wready}, 64'b01);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_pos);
      ok = 1'b0; t = 0;
      while (!ok && t < 100) begin ok = wready; tick(); t++; end
      if (!ok) chk("w_handshake", {63'd0, ok}, 64'd1);
      if (i < len) chk("b_not_early", {63'd0, bvalid}, 64'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_after_last", {63'd0, bvalid}, 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_clear_aw_ready", {62'd0, bvalid, awready}, 64'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    awvalid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; araddr = 0; arlen = 0; rready = 0;

    // Reset state
    tick(); tick();
    chk("reset_outputs", {25'd0, awready, arready, wready, bvalid, rvalid, rlast, wlast_err, rdata},
        64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {62'd0, awready, arready}, 64'b11);

    // Single-beat write then read at 0x10
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(32'h10, 0, 0);
    push(32'hDEADBEEF, 1'b1);
    rd(32'h10, 0);

    // 16-beat burst with partial strobe on beat 5 over an all-ones prefill
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
    wr(32'h100, 15, 15);
    for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = (i == 5) ? 4'h3 : 4'hF; end
    wr(32'h100, 15, 15);
    for (int i = 0; i < 16; i++) push((i == 5) ? 32'hFFFF0005 : 32'(i), i == 15);
    rd(32'h100, 15);

    // Wrap at the top of the array: words 1022, 1023, 0, 1
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + i; ws[i] = 4'hF; end
    wr(32'hFF8, 3, 3);
    push(32'hC2, 1'b0); push(32'hC3, 1'b1);
    rd(32'h0, 1);
    push(32'hC0, 1'b0); push(32'hC1, 1'b0); push(32'hC2, 1'b0); push(32'hC3, 1'b1);
    rd(32'hFF8, 3);

    // Concurrent 256-beat read (words 256..511) and write (words 512..767)
    for (int i = 0; i < 256; i++) begin wd[i] = 32'h10000000 + i; ws[i] = 4'hF; end
    wr(32'h400, 255, 255);
    for (int i = 0; i < 256; i++) begin
      wd[i] = 32'h20000000 + i;
      push(32'h10000000 + i, i == 255);
    end
    fork
      rd(32'h400, 255);
      wr(32'h800, 255, 255);
    join
    for (int i = 0; i < 256; i++) push(32'h20000000 + i, i == 255);
    rd(32'h800, 255);

    // Early wlast on beat 2 of a 4-beat burst (words 900..903)
    chk("wlast_err_clear", {63'd0, wlast_err}, 64'd0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0 + i; ws[i] = 4'hF; end
    wr(32'hE10, 3, 2);
    chk("wlast_err_set", {63'd0, wlast_err}, 64'd1);
    tick();
    chk("wlast_err_sticky", {63'd0, wlast_err}, 64'd1);
    for (int i = 0; i < 4; i++) push(32'hE0 + i, i == 3);
    rd(32'hE10, 3);

    // Reset in the middle of an 8-beat read
    push(32'h10000000, 1'b0); push(32'h10000001, 1'b0);
    rready = 1'b1;
    ar(32'h400, 7);
    tick(); tick();
    rready = 1'b0;
    tick();
    chk("r_hold_when_stalled", {31'd0, rvalid, rdata}, {31'd0, 1'b1, 32'h10000002});
    rst = 1'b1;
    tick();
    chk("rst_drops_rvalid", {62'd0, rvalid, wlast_err}, 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_mid_rst", {62'd0, awready, arready}, 64'b11);
    chk("no_pending_beats", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) push(32'hE0 + i, i == 3);
    rd(32'hE10, 3);
    push(32'hDEADBEEF, 1'b1);
    rd(32'h10, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
